// File: rtl/core_ctrl_pkg.sv
// Shared encodings and widths for the core run controller and its helpers.
package core_ctrl_pkg;

   localparam int IMEM_AW = 8;
   localparam int INSTR_W = 16;
   localparam int COUNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_LOAD   = 2'b01,
      ST_RUN    = 2'b10,
      ST_HALTED = 2'b11
   } state_e;

   typedef enum logic [1:0] {
      CMD_NOP  = 2'b00,
      CMD_LOAD = 2'b01,
      CMD_RUN  = 2'b10,
      CMD_STOP = 2'b11
   } cmd_e;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'b00,
      CAUSE_CORE = 2'b01,
      CAUSE_HOST = 2'b10,
      CAUSE_WDOG = 2'b11
   } cause_e;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating RUN-cycle counter; clear wins over enable.
module run_cycle_counter
   import core_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   output logic [COUNT_W-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != {COUNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/core_run_controller.sv
// Host-facing controller: loads instruction memory, runs the core and
// records why it stopped. reset is asynchronous and active low.
module core_run_controller
   import core_ctrl_pkg::*;
#(
   parameter logic [15:0] MAX_CYCLES = 16'd4000
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               host_cmd_valid,
   output logic               host_cmd_ready,
   input  logic [1:0]         host_cmd,
   input  logic [7:0]         host_len,
   input  logic               host_wvalid,
   output logic               host_wready,
   input  logic [INSTR_W-1:0] host_wdata,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               core_reset,
   input  logic               core_halt,
   output logic [1:0]         state,
   output logic [1:0]         halt_cause,
   output logic [COUNT_W-1:0] cycle_count,
   output logic               done
);

   state_e               state_q, state_d;
   cause_e               cause_q, exit_cause;
   cmd_e                 cmd;
   logic [IMEM_AW-1:0]   ptr_q;
   logic [IMEM_AW:0]     remaining_q;
   logic                 cmd_fire, word_fire;
   logic                 load_start, run_start, run_exit;

   // Both channels transfer on the rising edge where valid and ready are
   // high together; ready depends only on state, never on valid.
   assign cmd       = cmd_e'(host_cmd);
   assign cmd_fire  = host_cmd_valid & host_cmd_ready;
   assign word_fire = host_wvalid & host_wready;

   assign host_cmd_ready = (state_q != ST_LOAD);
   assign host_wready    = (state_q == ST_LOAD);
   assign imem_we        = word_fire;
   assign imem_addr      = ptr_q;
   assign imem_wdata     = host_wdata;
   assign core_reset     = (state_q != ST_RUN);
   assign state          = state_q;
   assign halt_cause     = cause_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      load_start = 1'b0;
      run_start  = 1'b0;
      run_exit   = 1'b0;
      exit_cause = CAUSE_NONE;
      case (state_q)
         ST_IDLE, ST_HALTED: begin
            load_start = cmd_fire && (cmd == CMD_LOAD);
            run_start  = cmd_fire && (cmd == CMD_RUN);
            if (load_start) begin
               state_d = ST_LOAD;
            end else if (run_start) begin
               state_d = ST_RUN;
            end
         end
         ST_LOAD: begin
            if (word_fire && (remaining_q == 9'd1)) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Core halt outranks a host STOP, which outranks the watchdog.
            if (core_halt) begin
               run_exit   = 1'b1;
               exit_cause = CAUSE_CORE;
            end else if (cmd_fire && (cmd == CMD_STOP)) begin
               run_exit   = 1'b1;
               exit_cause = CAUSE_HOST;
            end else if (cycle_count == MAX_CYCLES) begin
               run_exit   = 1'b1;
               exit_cause = CAUSE_WDOG;
            end
            if (run_exit) begin
               state_d = ST_HALTED;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q       <= '0;
         remaining_q <= '0;
         cause_q     <= CAUSE_NONE;
         done        <= 1'b0;
      end else begin
         done <= run_exit;
         if (load_start) begin
            ptr_q       <= '0;
            remaining_q <= (host_len == 8'd0) ? 9'd256 : {1'b0, host_len};
         end else if (word_fire) begin
            ptr_q       <= ptr_q + 1'b1;
            remaining_q <= remaining_q - 1'b1;
         end
         if (run_start) begin
            cause_q <= CAUSE_NONE;
         end else if (run_exit) begin
            cause_q <= exit_cause;
         end
      end
   end

   // The count freezes on the exit cycle so the host sees the cycle it stopped on.
   run_cycle_counter u_counter (
      .clk    (clk),
      .reset  (reset),
      .clear  (run_start),
      .enable ((state_q == ST_RUN) && !run_exit),
      .count  (cycle_count)
   );

endmodule

// File: tb/tb_core_run_controller.sv
// Scoreboard bench for core_run_controller: drivers push expected writes and
// halt records; a negedge monitor pops and compares as the DUT reports them.
module tb_core_run_controller;
   import core_ctrl_pkg::*;

   localparam logic [15:0] MAX_C = 16'd20;

   logic        clk;
   logic        reset;
   logic        host_cmd_valid;
   logic        host_cmd_ready;
   logic [1:0]  host_cmd;
   logic [7:0]  host_len;
   logic        host_wvalid;
   logic        host_wready;
   logic [15:0] host_wdata;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [15:0] imem_wdata;
   logic        core_reset;
   logic        core_halt;
   logic [1:0]  state;
   logic [1:0]  halt_cause;
   logic [15:0] cycle_count;
   logic        done;

   core_run_controller #(.MAX_CYCLES(MAX_C)) dut (
      .clk            (clk),
      .reset          (reset),
      .host_cmd_valid (host_cmd_valid),
      .host_cmd_ready (host_cmd_ready),
      .host_cmd       (host_cmd),
      .host_len       (host_len),
      .host_wvalid    (host_wvalid),
      .host_wready    (host_wready),
      .host_wdata     (host_wdata),
      .imem_we        (imem_we),
      .imem_addr      (imem_addr),
      .imem_wdata     (imem_wdata),
      .core_reset     (core_reset),
      .core_halt      (core_halt),
      .state          (state),
      .halt_cause     (halt_cause),
      .cycle_count    (cycle_count),
      .done           (done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   logic [23:0] exp_wr_q[$];    // {addr, data}
   logic [17:0] exp_halt_q[$];  // {cause, count}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor
   initial begin
      logic        prev_done;
      logic [23:0] w;
      logic [17:0] h;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            check("we_in_reset", imem_we, 0);
            prev_done = 1'b0;
         end else begin
            if (imem_we) begin
               if (exp_wr_q.size() == 0) begin
                  check("spurious_we", imem_we, 0);
               end else begin
                  w = exp_wr_q.pop_front();
                  check("imem_addr", imem_addr, w[23:16]);
                  check("imem_wdata", imem_wdata, w[15:0]);
               end
            end
            if (prev_done) check("done_one_cycle", done, 0);
            if (done) begin
               if (exp_halt_q.size() == 0) begin
                  check("spurious_done", done, 0);
               end else begin
                  h = exp_halt_q.pop_front();
                  check("halt_cause", halt_cause, h[17:16]);
                  check("cycle_count_at_halt", cycle_count, h[15:0]);
                  check("state_halted", state, ST_HALTED);
                  check("core_reset_halted", core_reset, 1);
               end
            end
            prev_done = done;
         end
      end
   end

   // drivers: all called at #1 after a rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [1:0] c, input logic [7:0] len);
      int b;
      b = 0;
      host_cmd_valid = 1'b1;
      host_cmd       = c;
      host_len       = len;
      while (!host_cmd_ready && b < 50) begin
         tick();
         b++;
      end
      if (b == 50) check("cmd_ready_timeout", host_cmd_ready, 1);
      tick();
      host_cmd_valid = 1'b0;
      host_cmd       = CMD_NOP;
   endtask

   task automatic send_word(input logic [15:0] d, input logic [7:0] addr);
      int b;
      b = 0;
      exp_wr_q.push_back({addr, d});
      host_wvalid = 1'b1;
      host_wdata  = d;
      while (!host_wready && b < 50) begin
         tick();
         b++;
      end
      if (b == 50) check("wready_timeout", host_wready, 1);
      tick();
      host_wvalid = 1'b0;
   endtask

   task automatic do_load(input int n, input logic [7:0] len_field, input bit directed);
      logic [15:0] d;
      send_cmd(CMD_LOAD, len_field);
      check("state_load", state, ST_LOAD);
      check("wready_load", host_wready, 1);
      check("cmd_ready_load", host_cmd_ready, 0);
      for (int i = 0; i < n; i++) begin
         if ((directed && i == 1) || (!directed && $urandom_range(0, 3) == 0)) tick();
         d = directed ? 16'hA001 + 16'(i) : 16'($urandom);
         send_word(d, 8'(i));
      end
      check("state_after_load", state, ST_IDLE);
   endtask

   // kind: 0 core halt, 1 host STOP, 2 both, 3 neither (watchdog)
   task automatic do_run(input int n, input int kind);
      logic [1:0]  exp_cause;
      logic [15:0] exp_cnt;
      int steps;
      int b;
      if (kind == 3 || n > int'(MAX_C)) begin
         exp_cause = CAUSE_WDOG;
         exp_cnt   = MAX_C;
      end else begin
         exp_cause = (kind == 1) ? CAUSE_HOST : CAUSE_CORE;
         exp_cnt   = 16'(n);
      end
      exp_halt_q.push_back({exp_cause, exp_cnt});
      send_cmd(CMD_RUN, 8'd0);
      check("state_run", state, ST_RUN);
      check("core_reset_run", core_reset, 0);
      check("count_start", cycle_count, 0);
      check("cause_cleared", halt_cause, CAUSE_NONE);
      steps = 0;
      if (n >= 2) begin
         host_cmd_valid = 1'b1;
         host_cmd       = 2'($urandom_range(0, 2));
         tick();
         host_cmd_valid = 1'b0;
         host_cmd       = CMD_NOP;
         steps = 1;
      end
      for (int i = steps; i < n; i++) tick();
      if (kind != 3) begin
         core_halt      = (kind == 0 || kind == 2);
         host_cmd_valid = (kind == 1 || kind == 2);
         host_cmd       = CMD_STOP;
         tick();
         core_halt      = 1'b0;
         host_cmd_valid = 1'b0;
         host_cmd       = CMD_NOP;
      end
      b = 0;
      while (state != ST_HALTED && b < 100) begin
         tick();
         b++;
      end
      if (b == 100) check("halted_timeout", state, ST_HALTED);
      repeat (3) tick();
      check("count_frozen", cycle_count, exp_cnt);
      check("cause_held", halt_cause, exp_cause);
   endtask

   initial begin
      reset          = 1'b0;
      host_cmd_valid = 1'b0;
      host_cmd       = CMD_NOP;
      host_len       = 8'd0;
      host_wvalid    = 1'b0;
      host_wdata     = 16'd0;
      core_halt      = 1'b0;
      repeat (3) tick();
      check("rst_state", state, ST_IDLE);
      check("rst_core_reset", core_reset, 1);
      check("rst_cmd_ready", host_cmd_ready, 1);
      check("rst_wready", host_wready, 0);
      check("rst_count", cycle_count, 0);
      check("rst_cause", halt_cause, 0);
      check("rst_done", done, 0);
      reset = 1'b1;
      tick();
      check("post_rst_state", state, ST_IDLE);
      check("post_rst_core_reset", core_reset, 1);
      check("post_rst_cmd_ready", host_cmd_ready, 1);

      do_load(3, 8'd3, 1'b1);
      do_run(10, 0);
      do_run(0, 3);
      do_run(7, 2);
      do_run(7, 1);
      do_run(20, 0);

      for (int it = 0; it < 14; it++) begin
         int l;
         if ($urandom_range(0, 1) == 0) begin
            l = $urandom_range(1, 40);
            do_load(l, 8'(l), 1'b0);
         end else begin
            do_run($urandom_range(0, 25), $urandom_range(0, 3));
         end
      end

      // full 256-word load, then reset in the middle of another one
      do_load(256, 8'd0, 1'b0);
      send_cmd(CMD_LOAD, 8'd0);
      for (int i = 0; i < 100; i++) send_word(16'($urandom), 8'(i));
      reset       = 1'b0;
      host_wvalid = 1'b1;
      host_wdata  = 16'h5A5A;
      #1;
      check("midload_rst_state", state, ST_IDLE);
      check("midload_rst_wready", host_wready, 0);
      check("midload_rst_we", imem_we, 0);
      check("midload_rst_core_reset", core_reset, 1);
      repeat (3) tick();
      reset = 1'b1;
      repeat (4) tick();
      check("post_midload_state", state, ST_IDLE);
      host_wvalid = 1'b0;
      do_load(5, 8'd5, 1'b0);
      do_run(4, 1);

      repeat (5) tick();
      check("wr_q_drained", exp_wr_q.size(), 0);
      check("halt_q_drained", exp_halt_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/core_run_controller.md
CORE_RUN_CONTROLLER -- requirements
Module: core_run_controller

Interface
REQ-001 Parameter MAX_CYCLES, default 16'd4000, is the watchdog limit in RUN cycles; legal range 1..16'hFFFE.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 host_cmd_valid  in  1  host command offered.
REQ-005 host_cmd_ready  out  1  controller accepts command; transfer on valid&ready.
REQ-006 host_cmd  in  2  00 NOP, 01 LOAD, 10 RUN, 11 STOP.
REQ-007 host_len  in  8  LOAD word count, sampled with LOAD; 0 means 256.
REQ-008 host_wvalid  in  1  instruction word offered.
REQ-009 host_wready  out  1  controller accepts word; transfer on wvalid&wready.
REQ-010 host_wdata  in  16  instruction word.
REQ-011 imem_we  out  1  instruction-memory write strobe.
REQ-012 imem_addr  out  8  instruction-memory write address.
REQ-013 imem_wdata  out  16  instruction-memory write data.
REQ-014 core_reset  out  1  active-high reset driven to the pipelined datapath.
REQ-015 core_halt  in  1  halt indication from the datapath fetch stage.
REQ-016 state  out  2  00 IDLE, 01 LOAD, 10 RUN, 11 HALTED.
REQ-017 halt_cause  out  2  00 none, 01 core halt, 10 host STOP, 11 watchdog.
REQ-018 cycle_count  out  16  RUN cycles elapsed, saturating at 16'hFFFF.
REQ-019 done  out  1  one-cycle pulse on entry to HALTED.

Function
REQ-020 host_cmd_ready SHALL be 1 in IDLE, RUN and HALTED, and 0 in LOAD.
REQ-021 host_wready SHALL be 1 only in LOAD.
REQ-022 imem_we SHALL equal host_wvalid&host_wready combinationally; imem_addr SHALL be the load pointer; imem_wdata SHALL equal host_wdata.
REQ-023 Accepted LOAD in IDLE/HALTED: next cycle state=LOAD, pointer=0, remaining=host_len (0 -> 256).
REQ-024 Each accepted word in LOAD: pointer+1 (wraps 255->0), remaining-1; the last word moves state to IDLE in the following cycle.
REQ-025 Accepted RUN in IDLE/HALTED: next cycle state=RUN, core_reset=0, cycle_count=0, halt_cause=00.
REQ-026 In RUN, cycle_count SHALL increment by 1 each cycle, saturating at 16'hFFFF.
REQ-027 RUN exit priority, same cycle: core_halt=1 -> cause 01; else accepted STOP -> cause 10; else cycle_count==MAX_CYCLES -> cause 11.
REQ-028 On a RUN exit: next cycle state=HALTED, core_reset=1, done=1 for exactly that one cycle; cycle_count SHALL freeze at its value.
REQ-029 LOAD and RUN commands accepted in RUN, STOP accepted in IDLE/HALTED, and NOP in any state SHALL be consumed with no effect.
REQ-030 core_halt outside RUN SHALL be ignored.
REQ-031 core_reset SHALL be 1 in every state except RUN.

Reset
REQ-032 Reset low SHALL immediately force state=IDLE, core_reset=1, pointer=0, remaining=0, cycle_count=0, halt_cause=00, done=0; host_cmd_ready reads 1, host_wready reads 0 and imem_we reads 0 while in IDLE.
REQ-033 Reset asserted mid-LOAD or mid-RUN SHALL abandon the operation; no further imem writes occur until a new LOAD is accepted after reset is released.

Structure
REQ-034 The state, command and halt_cause encodings SHALL live in a shared package, core_ctrl_pkg, along with the IMEM address width (8) and instruction width (16).
REQ-035 The saturating, clearable cycle counter SHALL be a sub-module, run_cycle_counter (inputs: clear, enable; output: 16-bit count).

Verification
REQ-036 Reset low, then high -> state=00, core_reset=1, host_cmd_ready=1, host_wready=0, cycle_count=0.
REQ-037 LOAD with host_len=3, words 16'hA001/16'hA002/16'hA003 with one wvalid gap -> imem writes at addr 0,1,2 in order; state returns to 00 one cycle after the third write.
REQ-038 RUN, core_halt raised after 10 RUN cycles -> core_reset falls the cycle after RUN is accepted; HALTED with halt_cause=01, cycle_count=10, done high for one cycle.
REQ-039 MAX_CYCLES=20, RUN with core_halt held 0 -> HALTED with halt_cause=11 and cycle_count=20.
REQ-040 In RUN, STOP and core_halt in the same cycle -> halt_cause=01; on a separate run, STOP alone -> halt_cause=10.
REQ-041 LOAD with host_len=0 streams 256 words; reset pulsed after 100 words -> state=00, imem_we stays 0 thereafter, and a new LOAD restarts writes at addr 0.
